// File: rtl/pc_exec_controller.sv
// pc_exec_controller: execution-mode sequencer for the fetch stage.
// Produces the global enable for the PC and the pipeline registers. It accepts
// RUN / STEP / STOP / CLEAR from the debug unit, freezes the pipeline when a
// HALT reaches writeback, and counts the cycles in which execution was enabled.
//
// Ports:
//   i_clock          system clock, rising edge
//   i_reset          synchronous, active-high reset
//   i_cmd_valid      command strobe, sampled only while o_cmd_ready=1
//   i_cmd            00 CLEAR, 01 RUN, 10 STEP, 11 STOP
//   i_program_loaded RUN/STEP are ignored while low
//   i_halt           HALT at writeback, sampled only while o_enable=1
//   o_enable         PC / pipeline enable (registered)
//   o_cmd_ready      a command can be accepted this cycle (low during STEP)
//   o_step_done      one-cycle pulse after a step that did not halt
//   o_halted         program halted; held until CLEAR or reset
//   o_cycle_count    edges at which o_enable was 1, saturating
module pc_exec_controller #(
  parameter int unsigned NB_CNT = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  input  logic              i_program_loaded,
  input  logic              i_halt,
  output logic              o_enable,
  output logic              o_cmd_ready,
  output logic              o_step_done,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_cycle_count
);

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  state_t state;
  logic   cmd_accept;

  // A command is taken only when the controller advertises ready.
  assign cmd_accept = i_cmd_valid & o_cmd_ready;

  // State register with Moore outputs updated alongside the next state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= S_IDLE;
      o_enable      <= 1'b0;
      o_cmd_ready   <= 1'b1;
      o_step_done   <= 1'b0;
      o_halted      <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      o_step_done <= 1'b0;

      // Count every enabled edge, including the one that samples i_halt;
      // a CLEAR assignment below overrides this.
      if (o_enable && (o_cycle_count != {NB_CNT{1'b1}})) begin
        o_cycle_count <= o_cycle_count + NB_CNT'(1);
      end

      case (state)
        S_IDLE: begin
          if (cmd_accept) begin
            case (i_cmd)
              CMD_CLEAR: o_cycle_count <= '0;
              CMD_RUN: begin
                if (i_program_loaded) begin
                  state    <= S_RUN;
                  o_enable <= 1'b1;
                end
              end
              CMD_STEP: begin
                if (i_program_loaded) begin
                  state       <= S_STEP;
                  o_enable    <= 1'b1;
                  o_cmd_ready <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end

        S_RUN: begin
          // Halt wins over a simultaneous STOP.
          if (i_halt) begin
            state    <= S_HALTED;
            o_enable <= 1'b0;
            o_halted <= 1'b1;
          end else if (cmd_accept && (i_cmd == CMD_STOP)) begin
            state    <= S_IDLE;
            o_enable <= 1'b0;
          end
        end

        S_STEP: begin
          o_enable    <= 1'b0;
          o_cmd_ready <= 1'b1;
          if (i_halt) begin
            state    <= S_HALTED;
            o_halted <= 1'b1;
          end else begin
            state       <= S_IDLE;
            o_step_done <= 1'b1;
          end
        end

        S_HALTED: begin
          if (cmd_accept && (i_cmd == CMD_CLEAR)) begin
            state         <= S_IDLE;
            o_halted      <= 1'b0;
            o_cycle_count <= '0;
          end
        end

        default: begin
          state       <= S_IDLE;
          o_enable    <= 1'b0;
          o_cmd_ready <= 1'b1;
          o_halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_exec_controller.sv
// Testbench for pc_exec_controller: directed scenarios plus random commands,
// checked every cycle against a behavioural model through an expected queue.
// A second instance with a 4-bit counter shares the stimulus for saturation.
module tb_pc_exec_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        loaded;
  logic        halt;

  logic        en32, rdy32, sd32, hl32;
  logic [31:0] cnt32;
  logic        en4, rdy4, sd4, hl4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  pc_exec_controller #(.NB_CNT(32)) dut32 (
    .i_clock(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_program_loaded(loaded), .i_halt(halt),
    .o_enable(en32), .o_cmd_ready(rdy32), .o_step_done(sd32),
    .o_halted(hl32), .o_cycle_count(cnt32)
  );

  pc_exec_controller #(.NB_CNT(4)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_program_loaded(loaded), .i_halt(halt),
    .o_enable(en4), .o_cmd_ready(rdy4), .o_step_done(sd4),
    .o_halted(hl4), .o_cycle_count(cnt4)
  );

  localparam logic [1:0] CLEAR = 2'd0, RUN = 2'd1, STEP = 2'd2, STOP = 2'd3;

  typedef struct {
    bit          en;
    bit          rdy;
    bit          sd;
    bit          hl;
    logic [31:0] c32;
    int unsigned c4;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: "running", "stepping", "halted" flags plus plain counters.
  bit          m_running, m_stepping, m_halted, m_done;
  longint      m_c32;
  int unsigned m_c4;

  task automatic model_edge();
    bit enabled, accepted;
    enabled  = m_running || m_stepping;
    accepted = cmd_valid && !m_stepping;
    m_done   = 1'b0;
    if (rst) begin
      m_running = 0; m_stepping = 0; m_halted = 0; m_c32 = 0; m_c4 = 0;
      return;
    end
    if (enabled) begin
      if (m_c32 < 64'hFFFF_FFFF) m_c32++;
      if (m_c4 < 15) m_c4++;
    end
    if (m_running) begin
      if (halt) begin m_running = 0; m_halted = 1; end
      else if (accepted && cmd == STOP) m_running = 0;
    end else if (m_stepping) begin
      m_stepping = 0;
      if (halt) m_halted = 1; else m_done = 1;
    end else if (m_halted) begin
      if (accepted && cmd == CLEAR) begin m_halted = 0; m_c32 = 0; m_c4 = 0; end
    end else if (accepted) begin
      if (cmd == CLEAR) begin m_c32 = 0; m_c4 = 0; end
      else if (cmd == RUN && loaded) m_running = 1;
      else if (cmd == STEP && loaded) m_stepping = 1;
    end
  endtask

  // One cycle: drive inputs at the falling edge, predict the post-edge outputs.
  task automatic drive(input bit v, input logic [1:0] c, input bit ld,
                       input bit h, input bit r);
    exp_t e;
    @(negedge clk);
    cmd_valid = v; cmd = c; loaded = ld; halt = h; rst = r;
    model_edge();
    e.en  = m_running || m_stepping;
    e.rdy = !m_stepping;
    e.sd  = m_done;
    e.hl  = m_halted;
    e.c32 = 32'(m_c32);
    e.c4  = m_c4;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit ld = 1'b1);
    for (int i = 0; i < n; i++) drive(1'b0, CLEAR, ld, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("enable",      longint'(en32),  longint'(e.en));
        chk("cmd_ready",   longint'(rdy32), longint'(e.rdy));
        chk("step_done",   longint'(sd32),  longint'(e.sd));
        chk("halted",      longint'(hl32),  longint'(e.hl));
        chk("count32",     longint'(cnt32), longint'(e.c32));
        chk("enable_n4",   longint'(en4),   longint'(e.en));
        chk("step_done_n4",longint'(sd4),   longint'(e.sd));
        chk("halted_n4",   longint'(hl4),   longint'(e.hl));
        chk("count4",      longint'(cnt4),  longint'(e.c4));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    cmd_valid = 0; cmd = CLEAR; loaded = 0; halt = 0; rst = 1;
    m_running = 0; m_stepping = 0; m_halted = 0; m_done = 0; m_c32 = 0; m_c4 = 0;

    drive(0, CLEAR, 1, 0, 1);
    drive(0, CLEAR, 1, 0, 1);

    // RUN, then STOP at the tenth enabled edge.
    drive(1, RUN, 1, 0, 0);
    idle(9);
    drive(1, STOP, 1, 0, 0);
    idle(2);

    // Two steps; a STEP during the step cycle is dropped.
    drive(1, CLEAR, 1, 0, 0);
    drive(1, STEP, 1, 0, 0);
    drive(1, STEP, 1, 0, 0);
    idle(3);
    drive(1, STEP, 1, 0, 0);
    idle(2);

    // Halt and STOP together after five enabled edges; RUN/STEP ignored; CLEAR.
    drive(1, CLEAR, 1, 0, 0);
    drive(1, RUN, 1, 0, 0);
    idle(4);
    drive(1, STOP, 1, 1, 0);
    drive(1, RUN, 1, 0, 0);
    drive(1, STEP, 1, 0, 0);
    drive(1, STOP, 1, 0, 0);
    idle(1);
    drive(1, CLEAR, 1, 0, 0);
    idle(1);

    // Step that halts: no step_done pulse.
    drive(1, STEP, 1, 0, 0);
    drive(0, CLEAR, 1, 1, 0);
    idle(2);
    drive(1, CLEAR, 1, 0, 0);

    // No program: RUN ignored. Then reset mid-run.
    drive(1, RUN, 0, 0, 0);
    idle(2, 0);
    drive(1, RUN, 1, 0, 0);
    idle(6, 0);
    drive(0, CLEAR, 0, 0, 1);
    idle(2);

    // Long run: 4-bit counter saturates at 15.
    drive(1, RUN, 1, 0, 0);
    idle(20);
    drive(1, STOP, 1, 0, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 99) == 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_exec_controller.md
Name: pc_exec_controller

Overview:
- Execution-mode sequencer for the fetch stage.
- Generates the global enable that drives the program counter and pipeline registers.
- Supports continuous run, single-step and stop commands from the debug unit.
- Detects program halt from the pipeline, freezes execution and reports an enabled-cycle count back to the debug unit.

Parameters:
NB_CNT, 32, width of the executed-cycle counter

Ports:
i_clock  in  1  system clock; all state changes on rising edge
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command strobe from the debug unit; sampled only when o_cmd_ready=1
i_cmd  in  2  command code: 00 CLEAR, 01 RUN, 10 STEP, 11 STOP
i_program_loaded  in  1  instruction memory holds a valid program; RUN/STEP are ignored while 0
i_halt  in  1  HALT instruction has reached writeback; sampled only while o_enable=1
o_enable  out  1  enable to the PC and pipeline registers; registered (Moore)
o_cmd_ready  out  1  controller can accept a command this cycle
o_step_done  out  1  one-cycle pulse after a single step completes
o_halted  out  1  program has halted; held until CLEAR or reset
o_cycle_count  out  NB_CNT  number of clock edges at which o_enable was 1

Behaviour:
- Reset: i_reset is synchronous, active-high; clock is i_clock. On reset: state IDLE, o_enable=0, o_step_done=0, o_halted=0, o_cycle_count=0. Reset overrides every other input, including mid-RUN and mid-STEP.
- States: IDLE, RUN, STEP, HALTED.
- Outputs per state: o_enable=1 only in RUN and STEP. o_halted=1 only in HALTED. o_cmd_ready=1 in IDLE, RUN and HALTED, 0 in STEP.
- Command acceptance: a command is accepted at an edge where i_cmd_valid=1 and o_cmd_ready=1. Commands presented while o_cmd_ready=0 are dropped (no queueing).
- IDLE transitions:
  - RUN with i_program_loaded=1 -> RUN.
  - STEP with i_program_loaded=1 -> STEP.
  - CLEAR -> stay IDLE, o_cycle_count cleared to 0.
  - STOP, or RUN/STEP with i_program_loaded=0 -> ignored.
- RUN transitions:
  - i_halt=1 -> HALTED.
  - Else accepted STOP -> IDLE (pause; o_cycle_count preserved).
  - RUN, STEP and CLEAR are ignored.
  - i_halt has priority over STOP in the same cycle.
- STEP: lasts exactly one cycle, so o_enable is high for exactly one cycle.
  - Next state is HALTED if i_halt=1, else IDLE.
  - o_step_done pulses high for the one cycle following STEP, only when the next state is IDLE (no pulse on a halt).
- HALTED transitions: only CLEAR is accepted -> IDLE, o_halted=0, o_cycle_count=0. RUN, STEP and STOP are ignored.
- Latency:
  - Command accepted at edge k -> o_enable changes in the cycle after edge k.
  - STOP accepted at edge k -> o_enable=0 from edge k.
  - i_halt sampled at edge k -> o_enable=0 from edge k; no further PC update after edge k.
- Counter:
  - Increments by 1 at every edge where o_enable=1, including the edge at which i_halt is sampled.
  - Saturates at all ones, no wrap.
  - CLEAR takes priority over increment. This cannot co-occur in practice, since CLEAR is only accepted in IDLE/HALTED where o_enable=0.
- i_halt while o_enable=0: ignored.
- i_program_loaded falling while in RUN: no effect; only STOP or halt leaves RUN.
- Illegal/unreachable state encoding: recover to IDLE on the next edge with o_enable=0.

Test Plan:
- Reset then RUN with i_program_loaded=1 at edge 0 -> o_enable=1 from cycle 1; STOP at edge 10 -> o_enable=0, o_cycle_count=10 (edges 1..10), o_cmd_ready=1.
- Two STEP commands separated by idle cycles -> o_enable high exactly one cycle each, o_step_done pulses once per step, o_cycle_count=2; a STEP presented during the STEP cycle (o_cmd_ready=0) is dropped.
- RUN, then i_halt=1 and STOP in the same cycle at edge 5 after start -> HALTED, o_halted=1, o_cycle_count=5; subsequent RUN/STEP ignored; CLEAR -> IDLE, o_cycle_count=0, o_halted=0.
- STEP with i_halt=1 during the step cycle -> HALTED, o_step_done stays 0, o_cycle_count=1.
- RUN with i_program_loaded=0 -> stays IDLE, o_enable=0; i_reset asserted mid-RUN at count 7 -> next cycle o_enable=0, o_cycle_count=0, IDLE.
- NB_CNT=4, RUN for 20 cycles -> o_cycle_count saturates at 15 and holds.
